// File: rtl/cluster_extract_n_if.sv
// ---------------------------------------------------------------------------
// cluster_extract_n_if
// Output handshake bundle of the cluster extractor: one cluster (pad address
// plus its count) is offered per cycle under a valid/ready handshake.
//   out_valid  master -> slave  a cluster is presented
//   out_ready  slave  -> master the presented cluster is accepted this cycle
//   out_adr    master -> slave  pad index of the presented cluster
//   out_cnt    master -> slave  count of that pad
// ---------------------------------------------------------------------------
interface cluster_extract_n_if #(
  parameter int MXADRB = 10,
  parameter int MXCNTB = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [MXADRB-1:0] out_adr;
  logic [MXCNTB-1:0] out_cnt;

  modport master (output out_valid, output out_adr, output out_cnt, input out_ready);
  modport slave  (input out_valid, input out_adr, input out_cnt, output out_ready);
endinterface

// File: rtl/cluster_extract_n.sv
// ---------------------------------------------------------------------------
// cluster_extract_n
// Multi-cluster priority extractor. A (delayed) latch strobe captures a frame
// of valid-pad flags and per-pad counts; the block then emits up to
// MXCLUSTERS clusters in ascending pad order, one per accepted handshake, by
// encoding the lowest set flag and clearing it.
// Ports:
//   clock, global_reset_n  clock and asynchronous active-low reset
//   latch_delay            extra delay (cycles) applied to latch_in
//   latch_in               frame strobe
//   vpfs_in / cnts_in      valid-pad flags and packed per-pad counts
//   out_if (master)        cluster valid/ready/adr/cnt handshake
//   frame_done             one-cycle pulse when a frame completes
//   n_found / truncated    result of the last completed frame (held)
//   frame_abort            one-cycle pulse when a frame is restarted early
// ---------------------------------------------------------------------------
module cluster_extract_n #(
  parameter int MXPADS     = 768,
  parameter int MXADRB     = 10,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 8,
  parameter int NFB        = $clog2(MXCLUSTERS + 1)
) (
  input  logic                       clock,
  input  logic                       global_reset_n,
  input  logic [3:0]                 latch_delay,
  input  logic                       latch_in,
  input  logic [MXPADS-1:0]          vpfs_in,
  input  logic [MXPADS*MXCNTB-1:0]   cnts_in,
  cluster_extract_n_if.master        out_if,
  output logic                       frame_done,
  output logic [NFB-1:0]             n_found,
  output logic                       truncated,
  output logic                       frame_abort
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEARCH, S_DONE} state_t;

  // Encoder leaves: padded to a power of two, padding leaves never valid.
  localparam int              NL       = 1 << MXADRB;
  localparam logic [NFB-1:0]  MAX_EMIT = NFB'(MXCLUSTERS);

  state_t                     state_q, state_d;
  logic [15:0]                dly_q, dly_d;
  logic [MXPADS-1:0]          mask_q, mask_d;
  logic [MXPADS*MXCNTB-1:0]   cnts_q, cnts_d;
  logic [NFB-1:0]             emitted_q, emitted_d;
  logic [NFB-1:0]             n_found_q, n_found_d;
  logic                       trunc_q, trunc_d;
  logic                       latch_en;
  logic                       search_more;

  // ------------------------------------------------------------------------
  // Latch delay line: dly_q[k] is latch_in delayed by k+1 cycles.
  // ------------------------------------------------------------------------
  always_comb begin
    dly_d    = {dly_q[14:0], latch_in};
    latch_en = dly_q[latch_delay];
  end

  // ------------------------------------------------------------------------
  // Lowest-wins binary tree encoder, heap-indexed: node n has children 2n
  // and 2n+1, leaves sit at NL+p. Node 1 is the root.
  // ------------------------------------------------------------------------
  logic [NL-1:0]          leaf_vld;
  logic [NL*MXCNTB-1:0]   leaf_cnt;
  logic                   node_vld [1:2*NL-1];
  logic [MXADRB-1:0]      node_adr [1:2*NL-1];
  logic [MXCNTB-1:0]      node_cnt [1:2*NL-1];

  always_comb begin
    leaf_vld = NL'(mask_q);
    leaf_cnt = (NL*MXCNTB)'(cnts_q);
    for (int p = 0; p < NL; p++) begin
      node_vld[NL+p] = leaf_vld[p];
      node_adr[NL+p] = MXADRB'(p);
      node_cnt[NL+p] = leaf_cnt[p*MXCNTB +: MXCNTB];
    end
    // Children always carry higher indices, so a descending sweep evaluates
    // every child before its parent.
    for (int n = NL - 1; n >= 1; n--) begin
      node_vld[n] = node_vld[2*n] | node_vld[2*n+1];
      node_adr[n] = node_vld[2*n] ? node_adr[2*n] : node_adr[2*n+1];
      node_cnt[n] = node_vld[2*n] ? node_cnt[2*n] : node_cnt[2*n+1];
    end
  end

  // ------------------------------------------------------------------------
  // Next-state and output logic.
  // ------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d          = state_q;
    mask_d           = mask_q;
    cnts_d           = cnts_q;
    emitted_d        = emitted_q;
    n_found_d        = n_found_q;
    trunc_d          = trunc_q;
    frame_done       = 1'b0;
    frame_abort      = 1'b0;
    out_if.out_valid = 1'b0;
    search_more      = (mask_q != '0) && (emitted_q < MAX_EMIT);

    case (state_q)
      S_IDLE: ;
      S_CAPTURE: begin
        emitted_d = '0;
        state_d   = S_SEARCH;
      end
      S_SEARCH: begin
        out_if.out_valid = search_more;
        if (!search_more) begin
          state_d = S_DONE;
        end else if (out_if.out_ready) begin
          mask_d[node_adr[1]] = 1'b0;
          emitted_d           = emitted_q + NFB'(1);
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        n_found_d  = emitted_q;
        trunc_d    = (mask_q != '0);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame strobe overrides everything: any handshake this cycle is
    // dropped and an in-flight frame is abandoned without reporting results.
    if (latch_en) begin
      frame_abort = (state_q == S_SEARCH) || (state_q == S_DONE);
      frame_done  = 1'b0;
      mask_d      = vpfs_in;
      cnts_d      = cnts_in;
      emitted_d   = '0;
      n_found_d   = n_found_q;
      trunc_d     = trunc_q;
      state_d     = S_CAPTURE;
    end

    // Results become visible together with frame_done, then stay held.
    n_found          = frame_done ? emitted_q : n_found_q;
    truncated        = frame_done ? (mask_q != '0) : trunc_q;
    out_if.out_adr   = out_if.out_valid ? node_adr[1] : '0;
    out_if.out_cnt   = out_if.out_valid ? node_cnt[1] : '0;
  end

  // ------------------------------------------------------------------------
  // State registers.
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      // NOTE: the captured frame is a plain register bank, not a RAM, and a
      // reset must discard it, so it is cleared along with the control state.
      mask_q    <= '0;
      cnts_q    <= '0;
      emitted_q <= '0;
      n_found_q <= '0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      mask_q    <= mask_d;
      cnts_q    <= cnts_d;
      emitted_q <= emitted_d;
      n_found_q <= n_found_d;
      trunc_q   <= trunc_d;
    end
  end

endmodule

// File: tb/tb_cluster_extract_n.sv
// ---------------------------------------------------------------------------
// tb_cluster_extract_n
// Directed and randomized frames for cluster_extract_n. Expected clusters are
// derived from the frame contents (ascending set flags, capped at MXCLUSTERS)
// and expected timing from the latch-to-output latency rules.
// ---------------------------------------------------------------------------
module tb_cluster_extract_n;
  localparam int MXPADS     = 768;
  localparam int MXADRB     = 10;
  localparam int MXCNTB     = 3;
  localparam int MXCLUSTERS = 8;
  localparam int NFB        = $clog2(MXCLUSTERS + 1);

  logic                     clock = 1'b0;
  logic                     global_reset_n;
  logic [3:0]               latch_delay;
  logic                     latch_in;
  logic [MXPADS-1:0]        vpfs_in;
  logic [MXPADS*MXCNTB-1:0] cnts_in;
  logic                     frame_done;
  logic [NFB-1:0]           n_found;
  logic                     truncated;
  logic                     frame_abort;

  cluster_extract_n_if #(.MXADRB(MXADRB), .MXCNTB(MXCNTB)) bus ();

  cluster_extract_n #(
    .MXPADS(MXPADS), .MXADRB(MXADRB), .MXCNTB(MXCNTB), .MXCLUSTERS(MXCLUSTERS)
  ) dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .latch_delay    (latch_delay),
    .latch_in       (latch_in),
    .vpfs_in        (vpfs_in),
    .cnts_in        (cnts_in),
    .out_if         (bus),
    .frame_done     (frame_done),
    .n_found        (n_found),
    .truncated      (truncated),
    .frame_abort    (frame_abort)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int last_n = 0;
  bit last_trunc = 1'b0;
  int exp_adr[$];
  int exp_cnt[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: clusters are the set flags in ascending order, at most
  // MXCLUSTERS of them; anything left over marks the frame truncated.
  task automatic build_model(input logic [MXPADS-1:0] v, input logic [MXPADS*MXCNTB-1:0] cv,
                             output int n, output bit tr);
    exp_adr.delete();
    exp_cnt.delete();
    tr = 1'b0;
    for (int i = 0; i < MXPADS; i++) begin
      if (v[i]) begin
        if (exp_adr.size() < MXCLUSTERS) begin
          exp_adr.push_back(i);
          exp_cnt.push_back(int'(cv[i*MXCNTB +: MXCNTB]));
        end else begin
          tr = 1'b1;
        end
      end
    end
    n = exp_adr.size();
  endtask

  // Called just after a falling edge: this cycle is T.
  task automatic launch(input logic [MXPADS-1:0] v, input logic [MXPADS*MXCNTB-1:0] cv,
                        input int d);
    vpfs_in     = v;
    cnts_in     = cv;
    latch_delay = 4'(d);
    latch_in    = 1'b1;
  endtask

  // Follows one frame from cycle T+c0 onward; ready is held low for `stall`
  // cycles once the first cluster shows up.
  task automatic watch(input logic [MXPADS-1:0] v, input logic [MXPADS*MXCNTB-1:0] cv,
                       input int d, input int stall, input int c0);
    int n;
    bit tr;
    int seen;
    int stall_left;
    bit first;
    bit done;
    build_model(v, cv, n, tr);
    seen = 0; stall_left = stall; first = 1'b1; done = 1'b0;
    for (int c = c0; c < c0 + 400 && !done; c++) begin
      @(negedge clock);
      latch_in = 1'b0;
      if (bus.out_valid) begin
        if (first) begin
          check("first_valid_cycle", c, d + 3);
          first = 1'b0;
        end
        if (seen < n) begin
          check("out_adr", 32'(bus.out_adr), exp_adr[seen]);
          check("out_cnt", 32'(bus.out_cnt), exp_cnt[seen]);
        end else begin
          check("valid_when_exhausted", 32'(bus.out_valid), 0);
        end
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          seen++;
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      if (frame_done) begin
        done = 1'b1;
        check("frame_done_cycle", c, d + 3 + n + ((n > 0) ? stall : 0) + 1);
        check("accepted", seen, n);
        check("n_found", 32'(n_found), n);
        check("truncated", 32'(truncated), 32'(tr));
        check("abort_with_done", 32'(frame_abort), 0);
        last_n = n;
        last_trunc = tr;
      end
    end
    if (!done) begin
      check("frame_done_timeout", 32'(frame_done), 1);
    end else begin
      @(negedge clock);
      check("done_pulse_width", 32'(frame_done), 0);
      check("n_found_held", 32'(n_found), last_n);
      check("truncated_held", 32'(truncated), 32'(last_trunc));
      check("valid_after_done", 32'(bus.out_valid), 0);
    end
  endtask

  task automatic rand_counts(output logic [MXPADS*MXCNTB-1:0] cv);
    for (int i = 0; i < MXPADS*MXCNTB; i++) cv[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [MXPADS-1:0]        v, va;
    logic [MXPADS*MXCNTB-1:0] cv, cva;
    int                       na;
    bit                       tra;

    global_reset_n = 1'b0;
    latch_in       = 1'b0;
    latch_delay    = 4'd0;
    vpfs_in        = '0;
    cnts_in        = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_adr", 32'(bus.out_adr), 0);
    check("rst_cnt", 32'(bus.out_cnt), 0);
    check("rst_n_found", 32'(n_found), 0);
    check("rst_truncated", 32'(truncated), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_abort", 32'(frame_abort), 0);
    global_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Pads 5/17/700 with counts 3/1/7.
    rand_counts(cv);
    v = '0;
    v[5] = 1'b1; v[17] = 1'b1; v[700] = 1'b1;
    cv[5*MXCNTB +: MXCNTB] = 3'd3; cv[17*MXCNTB +: MXCNTB] = 3'd1; cv[700*MXCNTB +: MXCNTB] = 3'd7;
    @(negedge clock); launch(v, cv, 0); watch(v, cv, 0, 0, 1);

    // Every pad set: capped at MXCLUSTERS, truncated.
    rand_counts(cv);
    v = '1;
    @(negedge clock); launch(v, cv, 0); watch(v, cv, 0, 0, 1);

    // Empty frame.
    v = '0;
    @(negedge clock); launch(v, cv, 0); watch(v, cv, 0, 0, 1);

    // Pads 10 and 20 with ready low for 4 cycles after the first valid.
    rand_counts(cv);
    v = '0; v[10] = 1'b1; v[20] = 1'b1;
    @(negedge clock); launch(v, cv, 0); watch(v, cv, 0, 4, 1);

    // Restart while the 2nd of 5 clusters is presented.
    rand_counts(cva);
    va = '0; va[3] = 1'b1; va[50] = 1'b1; va[100] = 1'b1; va[400] = 1'b1; va[767] = 1'b1;
    build_model(va, cva, na, tra);
    @(negedge clock); launch(va, cva, 0);
    @(negedge clock); latch_in = 1'b0;
    @(negedge clock);
    check("abort_pre_valid", 32'(bus.out_valid), 0);
    @(negedge clock);
    check("abort_first_adr", 32'(bus.out_adr), exp_adr[0]);
    rand_counts(cv);
    v = '0; v[9] = 1'b1; v[300] = 1'b1; v[301] = 1'b1;
    launch(v, cv, 0);
    @(negedge clock); latch_in = 1'b0;
    check("abort_pulse", 32'(frame_abort), 1);
    check("abort_valid_still", 32'(bus.out_valid), 1);
    check("abort_second_adr", 32'(bus.out_adr), exp_adr[1]);
    check("abort_no_done", 32'(frame_done), 0);
    check("abort_n_found_kept", 32'(n_found), last_n);
    watch(v, cv, 0, 0, 2);

    // latch_delay = 5, then reset in the middle of SEARCH.
    rand_counts(cv);
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[64] = 1'b1; v[128] = 1'b1; v[512] = 1'b1;
    build_model(v, cv, na, tra);
    @(negedge clock); launch(v, cv, 5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      latch_in = 1'b0;
      check("dly5_valid", 32'(bus.out_valid), 32'(c == 8));
    end
    check("dly5_adr", 32'(bus.out_adr), exp_adr[0]);
    @(negedge clock);
    global_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_adr", 32'(bus.out_adr), 0);
    check("mid_rst_cnt", 32'(bus.out_cnt), 0);
    check("mid_rst_n_found", 32'(n_found), 0);
    check("mid_rst_truncated", 32'(truncated), 0);
    check("mid_rst_done", 32'(frame_done), 0);
    @(negedge clock);
    global_reset_n = 1'b1;
    last_n = 0; last_trunc = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst_idle_valid", 32'(bus.out_valid), 0);
    check("post_rst_idle_done", 32'(frame_done), 0);

    // Randomized frames: sparse to over-full, varied delay and stalls.
    for (int r = 0; r < 10; r++) begin
      int nb, d, s;
      nb = $urandom_range(0, 12);
      d  = $urandom_range(0, 3);
      s  = $urandom_range(0, 3);
      v  = '0;
      for (int j = 0; j < nb; j++) v[$urandom_range(0, MXPADS-1)] = 1'b1;
      rand_counts(cv);
      @(negedge clock); launch(v, cv, d); watch(v, cv, d, s, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
